register_slice_sync_rstn: RTL and testbench

REGISTER_SLICE_SYNC_RSTN -- requirements
Module: register_slice_sync_rstn

---
 rtl/svlib_pkg.sv | 21 ++
 rtl/register_en_sync_rstn.sv | 23 ++
 rtl/register_slice_sync_rstn.sv | 100 ++++++++++
 tb/tb_register_slice_sync_rstn.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/svlib_pkg.sv
`default_nettype none
// svlib_pkg: shared types and helpers for the register slice.
// Rev 1.0
package svlib_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } slice_state_t;

  function automatic logic [1:0] state_count(input slice_state_t st);
    case (st)
      ONE:     return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/register_en_sync_rstn.sv
`default_nettype none
// register_en_sync_rstn: WIDTH-bit register with load enable, sync active-low clear.
// Rev 1.0
module register_en_sync_rstn #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/register_slice_sync_rstn.sv
`default_nettype none
// register_slice_sync_rstn: fully registered valid/ready slice with a one-entry skid buffer.
// Rev 1.0
module register_slice_sync_rstn
  import svlib_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       count
);

  slice_state_t     state;
  slice_state_t     next_state;
  logic             s_fire;
  logic             m_fire;
  logic             main_en;
  logic             skid_en;
  logic             load_skid;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;

  assign s_fire = s_valid & s_ready;
  assign m_fire = m_valid & m_ready;
  assign main_d = load_skid ? skid_q : s_data;

  always_comb begin
    next_state = state;
    main_en    = 1'b0;
    skid_en    = 1'b0;
    load_skid  = 1'b0;
    case (state)
      EMPTY: begin
        if (s_fire) begin
          main_en    = 1'b1;
          next_state = ONE;
        end
      end
      ONE: begin
        if (s_fire && m_fire) begin
          main_en = 1'b1;
        end else if (s_fire) begin
          skid_en    = 1'b1;
          next_state = FULL;
        end else if (m_fire) begin
          next_state = EMPTY;
        end
      end
      FULL: begin
        // s_ready is low here, so only the drain side can move
        if (m_fire) begin
          main_en    = 1'b1;
          load_skid  = 1'b1;
          next_state = ONE;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  // Handshake outputs are computed from next_state so they leave the slice straight from flops.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= EMPTY;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      count   <= 2'd0;
    end else begin
      state   <= next_state;
      s_ready <= (next_state != FULL);
      m_valid <= (next_state != EMPTY);
      count   <= state_count(next_state);
    end
  end

  register_en_sync_rstn #(.WIDTH(WIDTH)) u_main (
    .clk  (clk),
    .rstn (rstn),
    .en   (main_en),
    .d    (main_d),
    .q    (m_data)
  );

  register_en_sync_rstn #(.WIDTH(WIDTH)) u_skid (
    .clk  (clk),
    .rstn (rstn),
    .en   (skid_en),
    .d    (s_data),
    .q    (skid_q)
  );

endmodule
`default_nettype wire

// File: tb/tb_register_slice_sync_rstn.sv
`default_nettype none
// tb_register_slice_sync_rstn: directed and random checks of the register slice.
// Rev 1.0
module tb_register_slice_sync_rstn;

  logic       clk = 1'b0;
  logic       rstn;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [1:0] count;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic       prev_hold;
  logic [7:0] prev_data;
  logic       sf;
  logic       mf;

  register_slice_sync_rstn #(.WIDTH(8)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic sr, input logic mv, input logic [1:0] cnt);
    check_value({tag, ".s_ready"}, 32'(s_ready), 32'(sr));
    check_value({tag, ".m_valid"}, 32'(m_valid), 32'(mv));
    check_value({tag, ".count"},   32'(count),   32'(cnt));
  endtask

  initial begin
    rstn    = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hEE;
    m_ready = 1'b1;

    // reset held three cycles with a payload offered
    for (int i = 0; i < 3; i++) begin
      step();
      check_state("rst_hold", 1'b0, 1'b0, 2'd0);
    end
    check_value("rst_mdata", 32'(m_data), 32'h0);
    rstn = 1'b1;
    step();
    check_state("rst_release", 1'b1, 1'b0, 2'd0);
    s_valid = 1'b0;
    step();
    check_state("rst_idle", 1'b1, 1'b0, 2'd0);

    // streaming with m_ready high
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i);
      step();
      check_value("stream_valid", 32'(m_valid), 32'h1);
      check_value("stream_data",  32'(m_data),  32'(i));
      check_value("stream_count", 32'(count),   32'h1);
    end
    s_valid = 1'b0;
    step();
    check_state("stream_drained", 1'b1, 1'b0, 2'd0);

    // backpressure fills the skid register
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hA1;
    step();
    s_data  = 8'hA2;
    step();
    s_valid = 1'b0;
    check_state("bp_full", 1'b0, 1'b1, 2'd2);
    check_value("bp_data", 32'(m_data), 32'hA1);
    step();
    check_state("bp_hold", 1'b0, 1'b1, 2'd2);
    check_value("bp_hold_data", 32'(m_data), 32'hA1);
    m_ready = 1'b1;
    step();
    check_state("bp_drain1", 1'b1, 1'b1, 2'd1);
    check_value("bp_drain1_data", 32'(m_data), 32'hA2);
    step();
    check_state("bp_drain2", 1'b1, 1'b0, 2'd0);

    // simultaneous push and pop while holding one entry
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h55;
    step();
    check_state("sim_one", 1'b1, 1'b1, 2'd1);
    check_value("sim_one_data", 32'(m_data), 32'h55);
    s_data  = 8'h66;
    m_ready = 1'b1;
    step();
    s_valid = 1'b0;
    check_state("sim_swap", 1'b1, 1'b1, 2'd1);
    check_value("sim_swap_data", 32'(m_data), 32'h66);
    step();
    check_state("sim_empty", 1'b1, 1'b0, 2'd0);

    // reset while full discards both payloads
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hB1;
    step();
    s_data  = 8'hB2;
    step();
    s_valid = 1'b0;
    check_state("rfull_full", 1'b0, 1'b1, 2'd2);
    rstn = 1'b0;
    step();
    check_state("rfull_rst", 1'b0, 1'b0, 2'd0);
    rstn    = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_state("rfull_after", 1'b1, 1'b0, 2'd0);
    end

    // random traffic against a queue scoreboard
    q.delete();
    prev_hold = 1'b0;
    prev_data = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 8'($urandom);
      m_ready = 1'($urandom_range(0, 1));
      #1;
      check_value("rnd_count",  32'(count),   32'(q.size()));
      check_value("rnd_valid",  32'(m_valid), 32'(q.size() != 0));
      check_value("rnd_sready", 32'(s_ready), 32'(q.size() < 2));
      if (prev_hold) begin
        check_value("rnd_stable_valid", 32'(m_valid), 32'h1);
        check_value("rnd_stable_data",  32'(m_data),  32'(prev_data));
      end
      sf = s_valid & (q.size() < 2);
      mf = m_ready & (q.size() != 0);
      if (mf) begin
        check_value("rnd_order", 32'(m_data), 32'(q[0]));
        void'(q.pop_front());
      end
      if (sf) q.push_back(s_data);
      prev_hold = m_valid & ~m_ready;
      prev_data = m_data;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
